// File: rtl/id_ex_reg_pkg.sv
// Shared widths and field groupings for the ID/EX pipeline register.
// Widths fall back to the core's standard values when no defines header has set them.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef REGISTER_LEN
`define REGISTER_LEN 32
`endif
`ifndef REGFILE_ADDRESS_LEN
`define REGFILE_ADDRESS_LEN 4
`endif
`ifndef EXECUTE_COMMAND_LEN
`define EXECUTE_COMMAND_LEN 4
`endif
`ifndef SHIFT_OPERAND_LEN
`define SHIFT_OPERAND_LEN 12
`endif
`ifndef BUBBLE_EXE_CMD
`define BUBBLE_EXE_CMD {`EXECUTE_COMMAND_LEN{1'b0}}
`endif

package id_ex_reg_pkg;

  localparam int ADDR_W       = `ADDRESS_LEN;
  localparam int REG_W        = `REGISTER_LEN;
  localparam int RF_ADDR_W    = `REGFILE_ADDRESS_LEN;
  localparam int EXE_CMD_W    = `EXECUTE_COMMAND_LEN;
  localparam int SHIFT_W      = `SHIFT_OPERAND_LEN;
  localparam int SIGNED_IMM_W = 24;

  typedef struct packed {
    logic                 mem_read;
    logic                 mem_write;
    logic                 wb_enable;
    logic                 branch_taken;
    logic                 status_write_enable;
    logic [EXE_CMD_W-1:0] exe_cmd;
  } ctrl_t;

  typedef struct packed {
    logic [REG_W-1:0]        val_rn;
    logic [REG_W-1:0]        val_rm;
    logic [RF_ADDR_W-1:0]    src1;
    logic [RF_ADDR_W-1:0]    src2;
    logic                    immediate;
    logic [SIGNED_IMM_W-1:0] signed_imm;
    logic [SHIFT_W-1:0]      shift_operand;
    logic [RF_ADDR_W-1:0]    dest;
    logic                    carry;
  } data_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    mem_read:            1'b0,
    mem_write:           1'b0,
    wb_enable:           1'b0,
    branch_taken:        1'b0,
    status_write_enable: 1'b0,
    exe_cmd:             `BUBBLE_EXE_CMD
  };

  // A control group with nothing to do: the consumer's definition of a bubble.
  function automatic logic is_bubble(input ctrl_t c);
    return c == CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: async active-low reset, hold when en=0, synchronous clear.
// Latency one cycle; clear only takes effect on enabled edges, so a held stage stays held.
module pipe_reg_en_clr #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= clr ? CLR_VAL : d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: one-cycle latency, freeze holds everything, flush inserts a bubble.
// Optional stall/bubble performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       pc_in,
  input  logic                    mem_read_in,
  input  logic                    mem_write_in,
  input  logic                    wb_enable_in,
  input  logic                    branch_taken_in,
  input  logic                    status_write_enable_in,
  input  logic [EXE_CMD_W-1:0]    exe_cmd_in,
  input  logic [REG_W-1:0]        val_rn_in,
  input  logic [REG_W-1:0]        val_rm_in,
  input  logic [RF_ADDR_W-1:0]    src1_in,
  input  logic [RF_ADDR_W-1:0]    src2_in,
  input  logic                    immediate_in,
  input  logic [SIGNED_IMM_W-1:0] signed_imm_in,
  input  logic [SHIFT_W-1:0]      shift_operand_in,
  input  logic [RF_ADDR_W-1:0]    dest_in,
  input  logic                    carry_in,
  output logic [ADDR_W-1:0]       pc_out,
  output logic                    mem_read_out,
  output logic                    mem_write_out,
  output logic                    wb_enable_out,
  output logic                    branch_taken_out,
  output logic                    status_write_enable_out,
  output logic [EXE_CMD_W-1:0]    exe_cmd_out,
  output logic [REG_W-1:0]        val_rn_out,
  output logic [REG_W-1:0]        val_rm_out,
  output logic [RF_ADDR_W-1:0]    src1_out,
  output logic [RF_ADDR_W-1:0]    src2_out,
  output logic                    immediate_out,
  output logic [SIGNED_IMM_W-1:0] signed_imm_out,
  output logic [SHIFT_W-1:0]      shift_operand_out,
  output logic [RF_ADDR_W-1:0]    dest_out,
  output logic                    carry_out,
  output logic                    valid_out
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             bubble_cycles
`endif
);

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;
  logic  load_en;

  // Freeze wins over flush: a frozen flush is re-issued by EX once the stall clears.
  assign load_en = ~freeze;

  assign ctrl_d = '{
    mem_read:            mem_read_in,
    mem_write:           mem_write_in,
    wb_enable:           wb_enable_in,
    branch_taken:        branch_taken_in,
    status_write_enable: status_write_enable_in,
    exe_cmd:             exe_cmd_in
  };

  assign data_d = '{
    val_rn:        val_rn_in,
    val_rm:        val_rm_in,
    src1:          src1_in,
    src2:          src2_in,
    immediate:     immediate_in,
    signed_imm:    signed_imm_in,
    shift_operand: shift_operand_in,
    dest:          dest_in,
    carry:         carry_in
  };

  pipe_reg_en_clr #(
    .WIDTH   (ADDR_W),
    .RST_VAL (RESET_PC),
    .CLR_VAL (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst),
    .en    (load_en),
    .clr   (flush),
    .d     (pc_in),
    .q     (pc_out)
  );

  pipe_reg_en_clr #(
    .WIDTH   ($bits(ctrl_t)),
    .RST_VAL (CTRL_BUBBLE),
    .CLR_VAL (CTRL_BUBBLE)
  ) u_ctrl (
    .clk   (clk),
    .rst_n (rst),
    .en    (load_en),
    .clr   (flush),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_reg_en_clr #(
    .WIDTH   ($bits(data_t)),
    .RST_VAL ('0),
    .CLR_VAL ('0)
  ) u_data (
    .clk   (clk),
    .rst_n (rst),
    .en    (load_en),
    .clr   (flush),
    .d     (data_d),
    .q     (data_q)
  );

  pipe_reg_en_clr #(
    .WIDTH   (1),
    .RST_VAL (1'b0),
    .CLR_VAL (1'b0)
  ) u_valid (
    .clk   (clk),
    .rst_n (rst),
    .en    (load_en),
    .clr   (flush),
    .d     (1'b1),
    .q     (valid_out)
  );

  assign mem_read_out            = ctrl_q.mem_read;
  assign mem_write_out           = ctrl_q.mem_write;
  assign wb_enable_out           = ctrl_q.wb_enable;
  assign branch_taken_out        = ctrl_q.branch_taken;
  assign status_write_enable_out = ctrl_q.status_write_enable;
  assign exe_cmd_out             = ctrl_q.exe_cmd;

  assign val_rn_out        = data_q.val_rn;
  assign val_rm_out        = data_q.val_rm;
  assign src1_out          = data_q.src1;
  assign src2_out          = data_q.src2;
  assign immediate_out     = data_q.immediate;
  assign signed_imm_out    = data_q.signed_imm;
  assign shift_operand_out = data_q.shift_operand;
  assign dest_out          = data_q.dest;
  assign carry_out         = data_q.carry;

`ifdef ID_EX_PERF_CNT_EN
  logic bubble_evt;

  // Counts bubbles entering EX, whether created here by flush or handed over by ID.
  assign bubble_evt = flush | is_bubble(ctrl_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else if (freeze) begin
      if (stall_cycles != 32'hFFFF_FFFF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end else if (bubble_evt && (bubble_cycles != 32'hFFFF_FFFF)) begin
      bubble_cycles <= bubble_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed vector table, multi-cycle corner sequences, random run.
// Expected values come from a rule-level model of load / freeze / flush / reset.
module tb_id_ex_reg;

  localparam logic [31:0] RPC = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic        mem_read;
    logic        mem_write;
    logic        wb_enable;
    logic        branch_taken;
    logic        swe;
    logic [3:0]  exe_cmd;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        immediate;
    logic [23:0] signed_imm;
    logic [11:0] shift_operand;
    logic [3:0]  dest;
    logic        carry;
  } fields_t;

  typedef struct {
    string   name;
    fields_t in;
    logic    frz;
    logic    fl;
    fields_t exp;
    logic    exp_v;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    freeze;
  logic    flush;
  fields_t din;
  fields_t dout;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        mem_read_out, mem_write_out, wb_enable_out, branch_taken_out, swe_out;
  logic [3:0]  exe_cmd_out, src1_out, src2_out, dest_out;
  logic        immediate_out, carry_out, valid_out;
  logic [23:0] signed_imm_out;
  logic [11:0] shift_operand_out;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cycles, bubble_cycles;
`endif

  always #5 clk = ~clk;

  id_ex_reg #(.RESET_PC(RPC)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .freeze                  (freeze),
    .flush                   (flush),
    .pc_in                   (din.pc),
    .mem_read_in             (din.mem_read),
    .mem_write_in            (din.mem_write),
    .wb_enable_in            (din.wb_enable),
    .branch_taken_in         (din.branch_taken),
    .status_write_enable_in  (din.swe),
    .exe_cmd_in              (din.exe_cmd),
    .val_rn_in               (din.val_rn),
    .val_rm_in               (din.val_rm),
    .src1_in                 (din.src1),
    .src2_in                 (din.src2),
    .immediate_in            (din.immediate),
    .signed_imm_in           (din.signed_imm),
    .shift_operand_in        (din.shift_operand),
    .dest_in                 (din.dest),
    .carry_in                (din.carry),
    .pc_out                  (pc_out),
    .mem_read_out            (mem_read_out),
    .mem_write_out           (mem_write_out),
    .wb_enable_out           (wb_enable_out),
    .branch_taken_out        (branch_taken_out),
    .status_write_enable_out (swe_out),
    .exe_cmd_out             (exe_cmd_out),
    .val_rn_out              (val_rn_out),
    .val_rm_out              (val_rm_out),
    .src1_out                (src1_out),
    .src2_out                (src2_out),
    .immediate_out           (immediate_out),
    .signed_imm_out          (signed_imm_out),
    .shift_operand_out       (shift_operand_out),
    .dest_out                (dest_out),
    .carry_out               (carry_out),
    .valid_out               (valid_out)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .stall_cycles            (stall_cycles),
    .bubble_cycles           (bubble_cycles)
`endif
  );

  assign dout = {pc_out, mem_read_out, mem_write_out, wb_enable_out, branch_taken_out, swe_out,
                 exe_cmd_out, val_rn_out, val_rm_out, src1_out, src2_out, immediate_out,
                 signed_imm_out, shift_operand_out, dest_out, carry_out};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  fields_t     m;
  logic        mv;
  logic [31:0] m_stall;
  logic [31:0] m_bub;

  function automatic fields_t bubble();
    fields_t b = '0;
    b.pc = RPC;
    return b;
  endfunction

  function automatic logic no_ctrl(input fields_t f);
    return !(f.mem_read || f.mem_write || f.wb_enable || f.branch_taken || f.swe) && (f.exe_cmd == 4'd0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m       = bubble();
    mv      = 1'b0;
    m_stall = 32'd0;
    m_bub   = 32'd0;
  endtask

  task automatic model_edge(input fields_t in, input logic frz, input logic fl);
    if (frz) begin
      m_stall = sat_inc(m_stall);
    end else begin
      if (fl || no_ctrl(in)) m_bub = sat_inc(m_bub);
      if (fl) begin
        m  = bubble();
        mv = 1'b0;
      end else begin
        m  = in;
        mv = 1'b1;
      end
    end
  endtask

  task automatic check_out(input string nm, input fields_t exp, input logic exp_v);
    n_cmp++;
    if (dout !== exp || valid_out !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got fields=%h valid=%b, want fields=%h valid=%b", nm, dout, valid_out, exp, exp_v);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check_perf(input string nm);
`ifdef ID_EX_PERF_CNT_EN
    check32({nm, "_stall"}, stall_cycles, m_stall);
    check32({nm, "_bubble"}, bubble_cycles, m_bub);
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic step(input fields_t in, input logic frz, input logic fl, input string nm);
    din    = in;
    freeze = frz;
    flush  = fl;
    #4;
    check_out({nm, "_pre_edge"}, m, mv);
    model_edge(in, frz, fl);
    @(posedge clk);
    @(negedge clk);
    check_out(nm, m, mv);
    check_perf(nm);
  endtask

  task automatic async_reset(input string nm);
    rst = 1'b0;
    model_reset();
    #1;
    check_out({nm, "_async"}, m, mv);
    check_perf({nm, "_async"});
    @(posedge clk);
    @(negedge clk);
    check_out({nm, "_held"}, m, mv);
    rst = 1'b1;
  endtask

  function automatic fields_t rand_fields();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[154:0];
  endfunction

  vec_t    vt[$];
  fields_t f_add, f_str, f_zc, f_x1, f_x2, f_x3, f_pc10;

  initial begin
    f_add = '0; f_add.pc = 32'h8; f_add.exe_cmd = 4'b0010; f_add.dest = 4'd3;
    f_add.val_rn = 32'd7; f_add.wb_enable = 1'b1;
    f_x1 = '0; f_x1.pc = 32'h14; f_x1.exe_cmd = 4'b0100; f_x1.val_rm = 32'hDEAD_BEEF;
    f_x1.mem_read = 1'b1; f_x1.src1 = 4'd9;
    f_x2 = f_x1; f_x2.pc = 32'h18; f_x2.signed_imm = 24'hABCDEF; f_x2.carry = 1'b1;
    f_x3 = f_x2; f_x3.pc = 32'h1C; f_x3.shift_operand = 12'hF0F; f_x3.branch_taken = 1'b1;
    f_str = '0; f_str.pc = 32'h20; f_str.mem_write = 1'b1; f_str.exe_cmd = 4'b0010;
    f_str.src2 = 4'd5; f_str.val_rm = 32'd99; f_str.immediate = 1'b1;
    f_zc = '0; f_zc.pc = 32'h40; f_zc.val_rn = 32'h1234; f_zc.dest = 4'd7; f_zc.swe = 1'b0;
    f_pc10 = '0; f_pc10.pc = 32'h10;

    vt.push_back('{"load_add",      f_add, 1'b0, 1'b0, f_add,    1'b1});
    vt.push_back('{"freeze_1",      f_x1,  1'b1, 1'b0, f_add,    1'b1});
    vt.push_back('{"freeze_2",      f_x2,  1'b1, 1'b0, f_add,    1'b1});
    vt.push_back('{"freeze_3",      f_x3,  1'b1, 1'b0, f_add,    1'b1});
    vt.push_back('{"unfreeze_load", f_x3,  1'b0, 1'b0, f_x3,     1'b1});
    vt.push_back('{"load_str",      f_str, 1'b0, 1'b0, f_str,    1'b1});
    vt.push_back('{"freeze_flush",  f_x1,  1'b1, 1'b1, f_str,    1'b1});
    vt.push_back('{"flush_after",   f_str, 1'b0, 1'b1, bubble(), 1'b0});
    vt.push_back('{"zero_ctrl_ld",  f_zc,  1'b0, 1'b0, f_zc,     1'b1});
    vt.push_back('{"flush_load",    f_add, 1'b0, 1'b1, bubble(), 1'b0});
    vt.push_back('{"reload_add",    f_add, 1'b0, 1'b0, f_add,    1'b1});

    din = '0; freeze = 1'b0; flush = 1'b0; rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    #2;
    check_out("reset_state", bubble(), 1'b0);
    check_perf("reset_state");
    @(negedge clk);
    rst = 1'b1;

    // Directed table; each row's expectation is written out explicitly above.
    foreach (vt[i]) begin
      din    = vt[i].in;
      freeze = vt[i].frz;
      flush  = vt[i].fl;
      #4;
      check_out({vt[i].name, "_pre_edge"}, m, mv);
      model_edge(vt[i].in, vt[i].frz, vt[i].fl);
      @(posedge clk);
      @(negedge clk);
      check_out({vt[i].name, "_model"}, m, mv);
      n_cmp++;
      if (dout !== vt[i].exp || valid_out !== vt[i].exp_v) begin
        n_bad++;
        $display("FAIL %s: got fields=%h valid=%b, want fields=%h valid=%b",
                 vt[i].name, dout, valid_out, vt[i].exp, vt[i].exp_v);
      end
    end

    // Reset mid-freeze with a writeback entry live, then the first edge loads normally.
    step(f_add, 1'b0, 1'b0, "pre_rst_load");
    check32("pre_rst_wb", {31'd0, wb_enable_out}, 32'd1);
    freeze = 1'b1;
    async_reset("rst_mid_freeze");
    step(f_pc10, 1'b0, 1'b0, "post_rst_load");
    check32("post_rst_pc", pc_out, 32'h10);
    check32("post_rst_valid", {31'd0, valid_out}, 32'd1);

`ifdef ID_EX_PERF_CNT_EN
    // Fresh counters: two stalls, one flush, one zero-control load.
    async_reset("perf_rst");
    step(f_add, 1'b1, 1'b0, "perf_frz1");
    step(f_add, 1'b1, 1'b0, "perf_frz2");
    step(f_str, 1'b0, 1'b1, "perf_flush");
    step(f_zc,  1'b0, 1'b0, "perf_zc");
    check32("perf_stall_2", stall_cycles, 32'd2);
    check32("perf_bubble_2", bubble_cycles, 32'd2);

    force dut.stall_cycles  = 32'hFFFF_FFFF;
    force dut.bubble_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles;
    release dut.bubble_cycles;
    m_stall = 32'hFFFF_FFFF;
    m_bub   = 32'hFFFF_FFFF;
    step(f_add, 1'b1, 1'b0, "sat_stall");
    step(f_add, 1'b0, 1'b1, "sat_bubble");
    check32("sat_stall_hold", stall_cycles, 32'hFFFF_FFFF);
    check32("sat_bubble_hold", bubble_cycles, 32'hFFFF_FFFF);
`endif

    // Random run with occasional async resets.
    for (int k = 0; k < 400; k++) begin
      fields_t r;
      logic    rf, rl;
      r  = rand_fields();
      if ($urandom_range(0, 5) == 0) begin
        r.mem_read = 1'b0; r.mem_write = 1'b0; r.wb_enable = 1'b0;
        r.branch_taken = 1'b0; r.swe = 1'b0; r.exe_cmd = 4'd0;
      end
      rf = ($urandom_range(0, 3) == 0);
      rl = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rand_rst");
      end else begin
        step(r, rf, rl, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the ID stage and the EX stage of the ARM core.
- Captures every decoded control and datapath field from ID on each clock edge.
- Holds its contents under a memory-stall freeze.
- Converts the entry into a bubble on a branch flush.
- Drives the EX stage, and the forwarding/hazard logic through the registered source/destination fields.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into pc_out on reset and flush.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  memory stall; hold every register.
- flush  in  1  branch taken in EX; insert bubble.
- pc_in / pc_out  in/out  `ADDRESS_LEN  PC of the instruction.
- mem_read_in / mem_read_out  in/out  1  load.
- mem_write_in / mem_write_out  in/out  1  store.
- wb_enable_in / wb_enable_out  in/out  1  register writeback.
- branch_taken_in / branch_taken_out  in/out  1  branch.
- status_write_enable_in / status_write_enable_out  in/out  1  S-bit update.
- exe_cmd_in / exe_cmd_out  in/out  `EXECUTE_COMMAND_LEN  ALU command.
- val_rn_in / val_rn_out  in/out  `REGISTER_LEN  register-file read 1.
- val_rm_in / val_rm_out  in/out  `REGISTER_LEN  register-file read 2.
- src1_in / src1_out  in/out  `REGFILE_ADDRESS_LEN  Rn index (forwarding).
- src2_in / src2_out  in/out  `REGFILE_ADDRESS_LEN  Rm/Rd-store index (forwarding).
- immediate_in / immediate_out  in/out  1  I bit.
- signed_imm_in / signed_imm_out  in/out  24  branch offset.
- shift_operand_in / shift_operand_out  in/out  `SHIFT_OPERAND_LEN  operand-2 field.
- dest_in / dest_out  in/out  `REGFILE_ADDRESS_LEN  Rd.
- carry_in / carry_out  in/out  1  status C flag sampled with the instruction.
- valid_out  out  1  entry holds a real (non-flushed) instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs go to 0, except pc_out=RESET_PC.
  - valid_out=0.
  - reset is honoured at any time, including mid-freeze; after release the first edge loads normally.
- Priority per edge: freeze > flush > load.
- freeze=1: every register holds, including valid_out.
  - freeze+flush in the same cycle: hold. The branch causing the flush is itself frozen in EX, and EX re-asserts flush on the first unfrozen cycle.
- flush=1, freeze=0:
  - all control outputs cleared: mem_read, mem_write, wb_enable, branch_taken, status_write_enable, exe_cmd=0.
  - datapath fields cleared to 0; pc_out=RESET_PC.
  - valid_out=0.
- Otherwise: every *_in is captured into its *_out; valid_out=1.
  - A hazard bubble arriving from ID (all controls 0) is loaded as-is with valid_out=1. Bubble detection is the consumer's job via the control bits.
- Latency: exactly one cycle from ID inputs to outputs; no combinational in-to-out path.
- Outputs are registered only, and are stable for the whole cycle.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: two extra outputs, each 32-bit, saturating at 32'hFFFF_FFFF, reset to 0:
  - stall_cycles: increments every edge with freeze=1.
  - bubble_cycles: increments every unfrozen edge that either flushes, or loads with all five control bits and exe_cmd equal to 0.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Widths come from the shared defines.v macros: ADDRESS_LEN, REGISTER_LEN, REGFILE_ADDRESS_LEN, EXECUTE_COMMAND_LEN, SHIFT_OPERAND_LEN.
- Add BUBBLE_EXE_CMD (all zeros) to defines.v.
- One sub-module, pipe_reg_en_clr: parameterised width, async active-low reset, hold-enable, synchronous clear to a parameter value. Instantiate once per field group.

Test Plan:
- Reset: rst=0 mid-run with wb_enable_out=1 → all outputs 0, valid_out=0 immediately without a clock edge; after release, edge loads pc_in=32'h10 → pc_out=32'h10, valid_out=1.
- Load: pc_in=32'h8, exe_cmd_in=4'b0010, dest_in=4'd3, val_rn_in=32'd7, wb_enable_in=1 → all appear after one edge, unchanged until the next edge.
- Freeze: load an ADD, then hold freeze=1 for 3 cycles while inputs change → outputs constant for 3 cycles; first unfrozen edge captures the current inputs.
- Flush: mem_write_in=1, flush=1 → mem_write_out=0, exe_cmd_out=0, valid_out=0, pc_out=RESET_PC.
- Freeze+flush together: outputs hold the old STR entry; next cycle flush alone → bubble.
- With ID_EX_PERF_CNT_EN: 2 freeze, 1 flush, 1 zero-control load → stall_cycles=2, bubble_cycles=2. Force both counters to 32'hFFFF_FFFF → they stay at 32'hFFFF_FFFF.
